pc_sequencer: RTL

//  Next-PC controller for the single-cycle MIPS core. Computes pc_bar for the PC register each cycle.

---
 rtl/mips_pkg.sv | 15 +
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_target_calc.sv | 20 ++
 rtl/pc_sequencer.sv | 111 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core control blocks: sequencer state
// encoding and the default boot/exception vectors.
package mips_pkg;

   typedef enum logic [1:0] {
      ST_BOOT = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2,
      ST_TRAP = 2'd3
   } seq_state_t;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'h0000_0000;
   localparam logic [31:0] EXC_VECTOR_DEF   = 32'h8000_0180;

endpackage

// File: rtl/pc_sequencer_if.sv
// Bundle between the control unit / PC register and the next-PC sequencer.
interface pc_sequencer_if #(parameter int N = 32);

   logic [N-1:0] pc;
   logic         stall;
   logic         branch;
   logic         zero;
   logic [N-1:0] imm_ext;
   logic         jump;
   logic [25:0]  jump_index;
   logic         jr;
   logic [N-1:0] jr_target;
   logic         exc_req;
   logic         eret;
   logic         halt;
   logic         resume;
   logic [N-1:0] pc_bar;
   logic [N-1:0] epc;
   logic         fetch_valid;
   logic         in_handler;

   modport master (
      output pc, stall, branch, zero, imm_ext, jump, jump_index,
             jr, jr_target, exc_req, eret, halt, resume,
      input  pc_bar, epc, fetch_valid, in_handler
   );

   modport slave (
      input  pc, stall, branch, zero, imm_ext, jump, jump_index,
             jr, jr_target, exc_req, eret, halt, resume,
      output pc_bar, epc, fetch_valid, in_handler
   );

endinterface

// File: rtl/pc_target_calc.sv
// Combinational candidate next-PC values: sequential, branch and jump targets.
module pc_target_calc #(
   parameter int N = 32
) (
   input  logic [N-1:0] pc,
   input  logic [N-1:0] imm_ext,
   input  logic [25:0]  jump_index,
   output logic [N-1:0] pc_plus4,
   output logic [N-1:0] br_tgt,
   output logic [N-1:0] j_tgt
);

   always_comb begin
      pc_plus4 = pc + N'(4);
      br_tgt   = pc_plus4 + (imm_ext << 2);
      // jump field concatenation only makes sense for a 32-bit address
      j_tgt    = {pc_plus4[31:28], jump_index, 2'b00};
   end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: boot, sequential fetch, redirects, stall, halt and
// exception entry/return. Owns the EPC register.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_BOOT | first cycle after reset, presents RESET_VECTOR, no fetch
//   ST_RUN  | normal execution, priority mux selects next PC
//   ST_HALT | PC held, no fetch, waits for resume pulse
//   ST_TRAP | one-cycle bubble after exception entry
module pc_sequencer
   import mips_pkg::*;
#(
   parameter int           N            = 32,
   parameter logic [N-1:0] RESET_VECTOR = RESET_VECTOR_DEF,
   parameter logic [N-1:0] EXC_VECTOR   = EXC_VECTOR_DEF
) (
   input  logic           clk,
   input  logic           reset,
   pc_sequencer_if.slave  bus
);

   seq_state_t   state_q, state_d;
   logic [N-1:0] epc_q, epc_d;
   logic         in_handler_q, in_handler_d;

   logic [N-1:0] pc_plus4;
   logic [N-1:0] br_tgt;
   logic [N-1:0] j_tgt;
   logic [N-1:0] pc_bar_c;
   logic         fetch_valid_c;

   pc_target_calc #(.N(N)) u_target_calc (
      .pc         (bus.pc),
      .imm_ext    (bus.imm_ext),
      .jump_index (bus.jump_index),
      .pc_plus4   (pc_plus4),
      .br_tgt     (br_tgt),
      .j_tgt      (j_tgt)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_BOOT;
         epc_q        <= '0;
         in_handler_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         epc_q        <= epc_d;
         in_handler_q <= in_handler_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      epc_d         = epc_q;
      in_handler_d  = in_handler_q;
      pc_bar_c      = bus.pc;
      fetch_valid_c = 1'b0;

      case (state_q)
         ST_BOOT: begin
            pc_bar_c = RESET_VECTOR;
            state_d  = ST_RUN;
         end
         ST_RUN: begin
            fetch_valid_c = 1'b1;
            // exception outranks stall so a trap is never lost to a hold
            if (bus.exc_req) begin
               pc_bar_c     = EXC_VECTOR;
               epc_d        = bus.pc;
               in_handler_d = 1'b1;
               state_d      = ST_TRAP;
            end else if (bus.stall) begin
               pc_bar_c = bus.pc;
            end else if (bus.eret) begin
               pc_bar_c     = epc_q;
               in_handler_d = 1'b0;
            end else if (bus.halt) begin
               pc_bar_c = bus.pc;
               state_d  = ST_HALT;
            end else if (bus.jr) begin
               pc_bar_c = bus.jr_target;
            end else if (bus.jump) begin
               pc_bar_c = j_tgt;
            end else if (bus.branch && bus.zero) begin
               pc_bar_c = br_tgt;
            end else begin
               pc_bar_c = pc_plus4;
            end
         end
         ST_TRAP: begin
            state_d = ST_RUN;
         end
         ST_HALT: begin
            if (bus.resume) begin
               pc_bar_c = pc_plus4;
               state_d  = ST_RUN;
            end
         end
         default: begin
            state_d = ST_BOOT;
         end
      endcase
   end

   assign bus.pc_bar      = pc_bar_c;
   assign bus.epc         = epc_q;
   assign bus.fetch_valid = fetch_valid_c;
   assign bus.in_handler  = in_handler_q;

endmodule
